// File: rtl/rssi_meas_ctrl.sv
// rssi_meas_ctrl: sequences one RSSI / CCA measurement per start request.
// Enables the IQ->dB converter, discards P_SETTLE enabled samples while the
// converter pipeline and its EMA settle, then averages 2^P_WIN_LOG2 dB
// samples, tracks their peak and compares the mean with a latched threshold.
module rssi_meas_ctrl #(
    parameter int unsigned P_SETTLE   = 32,
    parameter int unsigned P_WIN_LOG2 = 4,
    parameter int unsigned P_DB_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_sample_vld,
    input  logic [P_DB_W-1:0] i_db_q8,
    input  logic [P_DB_W-1:0] i_cca_thr_q8,
    output logic              o_conv_en,
    output logic              o_busy,
    output logic              o_done,
    output logic [P_DB_W-1:0] o_rssi_avg_q8,
    output logic [P_DB_W-1:0] o_rssi_max_q8,
    output logic              o_cca_busy
);

    localparam int unsigned N_WIN  = 32'd1 << P_WIN_LOG2;
    localparam int unsigned ACC_W  = P_DB_W + P_WIN_LOG2;
    localparam int unsigned SCNT_W = 16;
    localparam int unsigned WCNT_W = P_WIN_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [SCNT_W-1:0]   settle_q,   settle_d;
    logic [WCNT_W-1:0]   win_q,      win_d;
    logic [ACC_W-1:0]    acc_q,      acc_d;
    logic [P_DB_W-1:0]   peak_q,     peak_d;
    logic [P_DB_W-1:0]   thr_q,      thr_d;
    logic [P_DB_W-1:0]   avg_q,      avg_d;
    logic [P_DB_W-1:0]   max_q,      max_d;
    logic                cca_q,      cca_d;

    logic [ACC_W-1:0]    acc_sum_s;
    logic [P_DB_W-1:0]   avg_s;
    logic [P_DB_W-1:0]   peak_nxt_s;
    logic                conv_en_s;

    // Converter enable follows the sample strobe only while a measurement runs.
    assign conv_en_s = i_sample_vld & ((state_q == ST_SETTLE) | (state_q == ST_MEASURE));

    // Running sum, truncated window mean and peak including the current sample.
    assign acc_sum_s  = acc_q + ACC_W'(i_db_q8);
    assign avg_s      = P_DB_W'(acc_sum_s >> P_WIN_LOG2);
    assign peak_nxt_s = (i_db_q8 > peak_q) ? i_db_q8 : peak_q;

    assign o_conv_en     = conv_en_s;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = (state_q == ST_DONE);
    assign o_rssi_avg_q8 = avg_q;
    assign o_rssi_max_q8 = max_q;
    assign o_cca_busy    = cca_q;

    // Next-state logic: sequencing, sample counting, accumulation and result capture.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        win_d    = win_q;
        acc_d    = acc_q;
        peak_d   = peak_q;
        thr_d    = thr_q;
        avg_d    = avg_q;
        max_d    = max_q;
        cca_d    = cca_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    state_d  = ST_SETTLE;
                    thr_d    = i_cca_thr_q8;
                    settle_d = {SCNT_W{1'b0}};
                    win_d    = {WCNT_W{1'b0}};
                    acc_d    = {ACC_W{1'b0}};
                    peak_d   = {P_DB_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (conv_en_s) begin
                    if (settle_q == SCNT_W'(P_SETTLE - 1)) begin
                        state_d = ST_MEASURE;
                    end else begin
                        settle_d = settle_q + {{(SCNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_MEASURE: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (conv_en_s) begin
                    acc_d  = acc_sum_s;
                    peak_d = peak_nxt_s;
                    win_d  = win_q + {{(WCNT_W-1){1'b0}}, 1'b1};
                    if (win_q == WCNT_W'(N_WIN - 1)) begin
                        state_d = ST_DONE;
                        avg_d   = avg_s;
                        max_d   = peak_nxt_s;
                        cca_d   = (avg_s >= thr_q);
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end else begin
                    state_d = ST_MEASURE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, accumulator and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= {SCNT_W{1'b0}};
            win_q    <= {WCNT_W{1'b0}};
            acc_q    <= {ACC_W{1'b0}};
            peak_q   <= {P_DB_W{1'b0}};
            thr_q    <= {P_DB_W{1'b0}};
            avg_q    <= {P_DB_W{1'b0}};
            max_q    <= {P_DB_W{1'b0}};
            cca_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            win_q    <= win_d;
            acc_q    <= acc_d;
            peak_q   <= peak_d;
            thr_q    <= thr_d;
            avg_q    <= avg_d;
            max_q    <= max_d;
            cca_q    <= cca_d;
        end
    end

endmodule

// File: tb/tb_rssi_meas_ctrl.sv
// Self-checking bench for rssi_meas_ctrl: directed and randomized measurements
// compared against a sample-list reference model.
module tb_rssi_meas_ctrl;

    localparam int S   = 32;
    localparam int WL  = 4;
    localparam int N   = 1 << WL;
    localparam int DBW = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           vld = 1'b0;
    logic [DBW-1:0] db = 16'h0000;
    logic [DBW-1:0] thr = 16'h0000;
    logic           conv_en, busy, done, cca;
    logic [DBW-1:0] avg, mx;

    int checks = 0;
    int errors = 0;

    // Results the model expects the DUT to be holding right now.
    logic [DBW-1:0] exp_avg = 16'h0000;
    logic [DBW-1:0] exp_max = 16'h0000;
    logic           exp_cca = 1'b0;

    rssi_meas_ctrl #(.P_SETTLE(S), .P_WIN_LOG2(WL), .P_DB_W(DBW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_sample_vld(vld), .i_db_q8(db), .i_cca_thr_q8(thr),
        .o_conv_en(conv_en), .o_busy(busy), .o_done(done),
        .o_rssi_avg_q8(avg), .o_rssi_max_q8(mx), .o_cca_busy(cca)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_results(input string tag);
        chk({tag, "_avg"}, {16'h0000, avg}, {16'h0000, exp_avg});
        chk({tag, "_max"}, {16'h0000, mx},  {16'h0000, exp_max});
        chk({tag, "_cca"}, {31'd0, cca},    {31'd0, exp_cca});
    endtask

    // One measurement. vmode: 0 vld=1, 1 toggle (high on odd cycles), 2 random.
    // dmode: 0 constant 0x1E00, 1 ramp 0x0100 step 0x0100, 2 random.
    // abort_cyc < 0 means no abort; exp_done < 0 means done cycle not pinned.
    task automatic measure(input logic [DBW-1:0] t, input int vmode, input int dmode,
                           input int abort_cyc, input int exp_done);
        int e;
        int cyc;
        logic [DBW-1:0] win[$];
        int unsigned sum;
        logic [DBW-1:0] pk;
        win.delete();
        e = 0;
        // cycle 0: request the measurement
        thr = t; start = 1'b1; abort = 1'b0; vld = 1'b1; db = 16'h0000;
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_conv_en", {31'd0, conv_en}, 32'd0);
        step();
        thr = 16'hFFFF;  // must have been latched at start
        for (cyc = 1; cyc < 3000; cyc++) begin
            start = 1'($urandom_range(0, 1));
            abort = (cyc == abort_cyc) ? 1'b1 : 1'b0;
            case (vmode)
                0:       vld = 1'b1;
                1:       vld = 1'(cyc % 2);
                default: vld = 1'($urandom_range(0, 1));
            endcase
            if (e >= S) begin
                case (dmode)
                    0:       db = 16'h1E00;
                    1:       db = 16'(16'h0100 * (e - S + 1));
                    default: db = 16'($urandom);
                endcase
            end else begin
                db = 16'($urandom);
            end
            #1;
            if (e == S + N) begin
                // results must appear now, in the done cycle
                sum = 0; pk = 16'h0000;
                foreach (win[i]) begin
                    sum += win[i];
                    if (win[i] > pk) pk = win[i];
                end
                exp_avg = 16'(sum / N);
                exp_max = pk;
                exp_cca = (exp_avg >= t);
                chk("done_pulse", {31'd0, done}, 32'd1);
                chk("done_busy", {31'd0, busy}, 32'd1);
                chk("done_conv_en", {31'd0, conv_en}, 32'd0);
                chk_results("done");
                if (exp_done >= 0) chk("done_cycle", 32'(cyc), 32'(exp_done));
                abort = 1'($urandom_range(0, 1));
                step();
                break;
            end
            chk("run_conv_en", {31'd0, conv_en}, {31'd0, vld});
            chk("run_busy", {31'd0, busy}, 32'd1);
            chk("run_done", {31'd0, done}, 32'd0);
            chk_results("run_hold");
            if (abort) begin
                step();
                break;
            end
            if (vld) begin
                if (e >= S) win.push_back(db);
                e++;
            end
            step();
        end
        if (cyc >= 3000) chk("timeout", 32'(cyc), 32'd0);
        // back in IDLE: no further measurement, results held
        start = 1'b0; abort = 1'b0; vld = 1'b1;
        #1;
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_done", {31'd0, done}, 32'd0);
        chk("post_conv_en", {31'd0, conv_en}, 32'd0);
        chk_results("post");
        step();
        chk("post2_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_conv_en", {31'd0, conv_en}, 32'd0);
        chk_results("rst");
        step();
        rst_n = 1'b1;
        step();

        measure(16'h1400, 0, 0, -1, 49);             // nominal, cca busy
        chk("t1_avg", {16'h0000, avg}, 32'h1E00);
        chk("t1_cca", {31'd0, cca}, 32'd1);
        measure(16'h1E01, 0, 0, -1, 49);             // threshold one above mean
        chk("t2_cca_lo", {31'd0, cca}, 32'd0);
        measure(16'h1E00, 0, 0, -1, 49);             // threshold equal to mean
        chk("t2_cca_eq", {31'd0, cca}, 32'd1);
        measure(16'h0800, 0, 1, -1, 49);             // ramp
        chk("t3_avg", {16'h0000, avg}, 32'h0880);
        chk("t3_max", {16'h0000, mx}, 32'h1000);
        measure(16'h1400, 1, 0, -1, 96);             // vld toggling
        for (int k = 0; k < 6; k++) begin
            measure(16'($urandom), 2, 2, -1, -1);
        end
        measure(16'h0000, 0, 2, 40, -1);             // abort in MEASURE
        measure(16'h0000, 2, 2, 10, -1);             // abort in SETTLE

        // start together with abort in IDLE: stays idle
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        #1;
        chk("start_abort_busy", {31'd0, busy}, 32'd0);
        step();

        // reset pulsed at cycle 20 of a run
        thr = 16'h0100; start = 1'b1; vld = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 20; c++) step();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_avg = 16'h0000; exp_max = 16'h0000; exp_cca = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_conv_en", {31'd0, conv_en}, 32'd0);
        chk_results("mid_rst");
        step();
        rst_n = 1'b1;
        step();
        measure(16'h1400, 0, 0, -1, 49);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
